uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver for the serial link: 8 data bits, no parity, 1 stop bit, LSB first, idle-high line. It oversamples the asynchronous `rxd` input on ticks derived from `clk`, validates start and stop bits, and delivers each byte to downstream logic as a one-cycle strobe. All logic runs in the `clk` domain; no derived clocks are used.

## Interface
- `CLK_FREQ`, 50000000: system clock frequency in Hz.
- `BAUD_RATE`, 19200: line bit rate.
- `OVERSAMPLE`, 16: ticks per bit; must be even and ≥ 4.
- `clk` input 1: system clock; all state changes on its rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `rxd` input 1: serial line, asynchronous to `clk`.
- `rx_data` output 8: last correctly framed byte.
- `rx_valid` output 1: one-`clk` strobe when `rx_data` updates.
- `frame_err` output 1: one-`clk` strobe when the stop bit is sampled low.
- `busy` output 1: high whenever the FSM is not in IDLE.

## Operation
- Tick divisor: `DIV = CLK_FREQ / (BAUD_RATE*OVERSAMPLE)`, integer truncation; 162 at the defaults.
- Tick counter: free-running from 0 to DIV-1. A tick fires for one `clk` when the counter equals DIV-1.
- Synchronizer: `rxd` passes through a 2-FF synchronizer that resets to 1. All sampling uses the synchronized value `rxs`.
- All FSM actions below happen only on tick cycles.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: when `rxs`=0, go to START and clear the sample counter `scnt`.
- START: increment `scnt`. When `scnt`=OVERSAMPLE/2-1 (mid-start-bit):
  - `rxs`=0: go to DATA with `scnt`=0 and `bidx`=0.
  - `rxs`=1: the start was a glitch; return to IDLE with no output.
- DATA: increment `scnt`. When `scnt`=OVERSAMPLE-1 (mid-bit):
  - Shift `rxs` into the MSB of an 8-bit shift register (right shift), clear `scnt`, increment `bidx`.
  - After the 8th bit, go to STOP.
- STOP: when `scnt`=OVERSAMPLE-1:
  - `rxs`=1: load `rx_data` from the shift register, pulse `rx_valid`, go to IDLE.
  - `rxs`=0: pulse `frame_err`; `rx_data` holds its previous value; go to WAIT_HIGH.
- WAIT_HIGH: go to IDLE on the first tick with `rxs`=1. This blocks a held-low break from re-triggering.
- `rx_valid` and `frame_err` are never high in the same cycle.
- No input backpressure: a new byte overwrites `rx_data` whether or not the previous one was consumed.
- `scnt` is 4 bits wide (`$clog2(OVERSAMPLE)`). `bidx` is 4 bits. The tick counter is `$clog2(DIV)` bits.

## Timing
- Reset values: `rx_data`=8'h00, `rx_valid`=0, `frame_err`=0, `busy`=0, FSM=IDLE, counters=0, synchronizer=1.
- `rst` low mid-frame aborts immediately. The partial byte is discarded and no strobe is issued.
- Input latency: 2 `clk` for synchronization, plus at most 1 tick for start detection.
- `rx_valid` rises in the `clk` after the mid-stop-bit tick, about 9.5 bit times after the start edge. It stays high for exactly 1 `clk`.
- `busy` rises 1 `clk` after the detecting tick and falls in the same cycle as `rx_valid`/`frame_err`, or when WAIT_HIGH/glitch exits to IDLE.
- Back-to-back frames: the next start bit can be detected on the tick after the return to IDLE; no idle gap is required.
- Sample-point jitter is ≤ 1 tick. Baud tolerance is ±3% at OVERSAMPLE=16.

## Structure
- Shared package `uart_pkg`:
  - `CLK_FREQ` and baud-rate constants shared with the transmitter side.
  - `uart_rx_state_t` enum.
  - Frame constants: `DATA_BITS`=8, `STOP_BITS`=1.
- One sub-module: `uart_baud_tick` (parameters CLK_FREQ, BAUD_RATE, OVERSAMPLE; output 1-`clk` `tick`). The transmitter can reuse it with OVERSAMPLE=1.

## Test plan
Bench uses CLK_FREQ=1600000, BAUD_RATE=10000 (DIV=10; 1 bit = 160 `clk`).
- Frame 0x55, stop=1 -> exactly one `rx_valid` pulse with `rx_data`=0x55; `frame_err` stays 0; `busy` low afterwards.
- Back-to-back 0xA5 then 0x3C with no idle gap -> two `rx_valid` pulses in order carrying 0xA5 and 0x3C, spaced 1600 ±10 `clk`.
- 30-`clk` low glitch on idle line -> `busy` pulses, no `rx_valid`/`frame_err`; next frame 0x01 is received correctly.
- Data 0xFF with stop bit low, line held low 20 bit times, then frame 0x12 -> one `frame_err` pulse; `rx_data` keeps its prior value; no further strobe during the break; then 0x12 is received.
- `rst` pulsed low mid-DATA of 0xF0 -> outputs at reset values immediately; no strobe for 0xF0; following frame 0x81 is received.
- Frames 0xC3 at baud +2.5% and -2.5% -> both received as 0xC3 with no `frame_err`.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Constants and types shared by the UART receiver and
//                transmitter: default clocking, frame shape, RX FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // System clock and line rate shared with the transmitter side
    localparam int UART_CLK_FREQ   = 50000000;
    localparam int UART_BAUD_RATE  = 19200;
    localparam int UART_OVERSAMPLE = 16;

    // Frame shape: 8N1, LSB first
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    // Receiver states, explicit 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } uart_rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_tick
//  Description : Free-running divider producing a one-clk tick every
//                CLK_FREQ/(BAUD_RATE*OVERSAMPLE) clocks. With OVERSAMPLE=1
//                it yields one tick per bit for the transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
    parameter int CLK_FREQ   = uart_pkg::UART_CLK_FREQ,
    parameter int BAUD_RATE  = uart_pkg::UART_BAUD_RATE,
    parameter int OVERSAMPLE = uart_pkg::UART_OVERSAMPLE
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    // A divide-by-one still needs a 1-bit counter; it simply never leaves 0
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Count 0..DIV-1 and wrap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver. Oversamples the synchronized line on
//                baud ticks, checks start and stop bits, and strobes each
//                good byte (rx_valid) or a bad stop bit (frame_err).
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = UART_CLK_FREQ,
    parameter int BAUD_RATE  = UART_BAUD_RATE,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] SCNT_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SCNT_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [3:0]    BIDX_LAST = 4'(DATA_BITS - 1);

    uart_rx_state_t state;
    uart_rx_state_t state_nxt;

    logic                 tick;
    logic [1:0]           sync;
    logic                 rxs;
    logic [SW-1:0]        scnt;
    logic [3:0]           bidx;
    logic [DATA_BITS-1:0] shreg;

    // Control decoded from the current state
    logic scnt_clr;
    logic scnt_inc;
    logic bidx_clr;
    logic shift_en;
    logic accept;
    logic reject;

    uart_baud_tick #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Two-flop synchronizer, resets to the idle-high line level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], rxd};
        end
    end

    assign rxs = sync[1];

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decision, evaluated only on ticks
    always_comb begin
        state_nxt = state;
        if (tick) begin
            case (state)
                ST_IDLE:      if (!rxs) state_nxt = ST_START;
                ST_START:     if (scnt == SCNT_MID) state_nxt = rxs ? ST_IDLE : ST_DATA;
                ST_DATA:      if (scnt == SCNT_LAST && bidx == BIDX_LAST) state_nxt = ST_STOP;
                ST_STOP:      if (scnt == SCNT_LAST) state_nxt = rxs ? ST_IDLE : ST_WAIT_HIGH;
                ST_WAIT_HIGH: if (rxs) state_nxt = ST_IDLE;
                default:      state_nxt = ST_IDLE;
            endcase
        end
    end

    // Datapath controls and busy flag from the current state
    always_comb begin
        busy     = (state != ST_IDLE);
        // Sample counter restarts on entry to each counted phase
        scnt_clr = tick && ((state == ST_IDLE) ||
                            (state == ST_START && scnt == SCNT_MID) ||
                            (state == ST_DATA  && scnt == SCNT_LAST) ||
                            (state == ST_STOP  && scnt == SCNT_LAST));
        scnt_inc = tick && (state == ST_START || state == ST_DATA || state == ST_STOP);
        bidx_clr = tick && (state == ST_START) && (scnt == SCNT_MID);
        shift_en = tick && (state == ST_DATA)  && (scnt == SCNT_LAST);
        accept   = tick && (state == ST_STOP)  && (scnt == SCNT_LAST) && rxs;
        reject   = tick && (state == ST_STOP)  && (scnt == SCNT_LAST) && !rxs;
    end

    // Counters, shift register and registered output strobes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scnt      <= '0;
            bidx      <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= accept;
            frame_err <= reject;
            if (scnt_clr) begin
                scnt <= '0;
            end else if (scnt_inc) begin
                scnt <= scnt + SW'(1);
            end
            if (bidx_clr) begin
                bidx <= '0;
            end else if (shift_en) begin
                bidx <= bidx + 4'd1;
            end
            // LSB arrives first, so shift right from the top
            if (shift_en) begin
                shreg <= {rxs, shreg[DATA_BITS-1:1]};
            end
            if (accept) begin
                rx_data <= shreg;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx at DIV=10 (160 clk per bit).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int BIT_CLKS = 160;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_rx #(
        .CLK_FREQ   (1600000),
        .BAUD_RATE  (10000),
        .OVERSAMPLE (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    // Cycle counter and strobe monitor
    int         cyc = 0;
    logic [7:0] vq[$];
    int         vt[$];
    int         fcnt = 0;
    bit         busy_seen = 1'b0;
    bit         prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid) begin
            vq.push_back(rx_data);
            vt.push_back(cyc);
        end
        if (frame_err) fcnt = fcnt + 1;
        if (busy) busy_seen = 1'b1;
        if (rx_valid && frame_err) begin
            errors = errors + 1;
            $display("FAIL strobe_exclusive actual=both_high required=not_both");
        end
        if (rx_valid && prev_valid) begin
            errors = errors + 1;
            $display("FAIL valid_width actual=2+clk required=1clk");
        end
        prev_valid = rx_valid;
    end

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks = checks + 1;
        if (act < lo || act > hi) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        vq.delete();
        vt.delete();
        fcnt      = 0;
        busy_seen = 1'b0;
    endtask

    // Start bit, 8 data bits LSB first, stop bit; line left at stop level
    task automatic send_frame(input logic [7:0] d, input logic stop, input int b);
        rxd = 1'b0;
        wait_clks(b);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            wait_clks(b);
        end
        rxd = stop;
        wait_clks(b);
    endtask

    function automatic int first_byte();
        return (vq.size() > 0) ? int'(vq[0]) : -1;
    endfunction

    function automatic int second_byte();
        return (vq.size() > 1) ? int'(vq[1]) : -1;
    endfunction

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         bclk;
        int         exp_valid;
        int         exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{8'h55, 1'b1, 160, 1, 0, 8'h55};
        vecs[1] = '{8'hC3, 1'b1, 164, 1, 0, 8'hC3};   // +2.5% slow bit
        vecs[2] = '{8'hC3, 1'b1, 156, 1, 0, 8'hC3};   // -2.5% fast bit
        vecs[3] = '{8'h3C, 1'b0, 160, 0, 1, 8'hC3};   // bad stop, data held
        vecs[4] = '{8'h00, 1'b1, 160, 1, 0, 8'h00};
        vecs[5] = '{8'hFF, 1'b1, 160, 1, 0, 8'hFF};
        vecs[6] = '{8'h80, 1'b1, 160, 1, 0, 8'h80};

        // Reset values
        rst = 1'b0;
        rxd = 1'b1;
        wait_clks(5);
        check("reset_rx_data",   int'(rx_data),   0);
        check("reset_rx_valid",  int'(rx_valid),  0);
        check("reset_frame_err", int'(frame_err), 0);
        check("reset_busy",      int'(busy),      0);
        rst = 1'b1;
        wait_clks(20);

        // Table-driven single frames
        foreach (vecs[k]) begin
            clear_mon();
            send_frame(vecs[k].data, vecs[k].stop, vecs[k].bclk);
            rxd = 1'b1;
            wait_clks(2 * BIT_CLKS);
            check($sformatf("vec%0d_valid_count", k), vq.size(), vecs[k].exp_valid);
            check($sformatf("vec%0d_ferr_count", k), fcnt, vecs[k].exp_ferr);
            check($sformatf("vec%0d_rx_data", k), int'(rx_data), int'(vecs[k].exp_data));
            check($sformatf("vec%0d_busy_after", k), int'(busy), 0);
            if (vecs[k].exp_valid == 1)
                check($sformatf("vec%0d_strobe_data", k), first_byte(), int'(vecs[k].exp_data));
        end

        // Back-to-back frames, no idle gap
        clear_mon();
        send_frame(8'hA5, 1'b1, BIT_CLKS);
        send_frame(8'h3C, 1'b1, BIT_CLKS);
        wait_clks(2 * BIT_CLKS);
        check("b2b_count", vq.size(), 2);
        check("b2b_first", first_byte(), 8'hA5);
        check("b2b_second", second_byte(), 8'h3C);
        check_range("b2b_spacing", (vt.size() > 1) ? (vt[1] - vt[0]) : -1, 1590, 1610);
        check("b2b_ferr", fcnt, 0);

        // Short low glitch on an idle line
        clear_mon();
        rxd = 1'b0;
        wait_clks(30);
        rxd = 1'b1;
        wait_clks(2 * BIT_CLKS);
        check("glitch_busy_seen", int'(busy_seen), 1);
        check("glitch_valid_count", vq.size(), 0);
        check("glitch_ferr_count", fcnt, 0);
        check("glitch_busy_after", int'(busy), 0);
        clear_mon();
        send_frame(8'h01, 1'b1, BIT_CLKS);
        wait_clks(2 * BIT_CLKS);
        check("post_glitch_count", vq.size(), 1);
        check("post_glitch_data", first_byte(), 8'h01);

        // Bad stop bit followed by a long break
        clear_mon();
        send_frame(8'hFF, 1'b0, BIT_CLKS);
        wait_clks(20 * BIT_CLKS);
        check("break_busy_held", int'(busy), 1);
        check("break_ferr_count", fcnt, 1);
        check("break_valid_count", vq.size(), 0);
        check("break_rx_data_held", int'(rx_data), 8'h01);
        rxd = 1'b1;
        wait_clks(2 * BIT_CLKS);
        check("break_busy_after", int'(busy), 0);
        check("break_ferr_total", fcnt, 1);
        clear_mon();
        send_frame(8'h12, 1'b1, BIT_CLKS);
        wait_clks(2 * BIT_CLKS);
        check("post_break_count", vq.size(), 1);
        check("post_break_data", first_byte(), 8'h12);

        // Reset in the middle of the data bits of 0xF0
        clear_mon();
        rxd = 1'b0;
        wait_clks(BIT_CLKS);            // start bit
        wait_clks(4 * BIT_CLKS);        // data bits 0..3 of 0xF0 are 0
        wait_clks(BIT_CLKS / 2);
        check("pre_reset_busy", int'(busy), 1);
        rst = 1'b0;
        wait_clks(1);
        check("midreset_rx_data",   int'(rx_data),   0);
        check("midreset_busy",      int'(busy),      0);
        check("midreset_rx_valid",  int'(rx_valid),  0);
        check("midreset_frame_err", int'(frame_err), 0);
        wait_clks(10);
        rxd = 1'b1;
        rst = 1'b1;
        wait_clks(3 * BIT_CLKS);
        check("post_reset_valid_count", vq.size(), 0);
        check("post_reset_ferr_count", fcnt, 0);
        clear_mon();
        send_frame(8'h81, 1'b1, BIT_CLKS);
        wait_clks(2 * BIT_CLKS);
        check("post_reset_frame_count", vq.size(), 1);
        check("post_reset_frame_data", first_byte(), 8'h81);
        check("post_reset_rx_data", int'(rx_data), 8'h81);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
